// File: rtl/pam4_pkg.sv
// rtl/pam4_pkg.sv - PAM4 symbol type, level indices and mapping helper shared by encoder, mapper and slicer.
package pam4_pkg;

  typedef logic [1:0] pam4_sym_t;

  localparam pam4_sym_t LVL_IDX_M3 = 2'd0;
  localparam pam4_sym_t LVL_IDX_M1 = 2'd1;
  localparam pam4_sym_t LVL_IDX_P1 = 2'd2;
  localparam pam4_sym_t LVL_IDX_P3 = 2'd3;

  localparam int PAM4_LEVEL_AMP_DEFAULT = 32;

  // Index m maps to (2m-3)*amp, evaluated in 32-bit signed arithmetic, then truncated.
  function automatic logic [7:0] pam4_level(input pam4_sym_t m, input int amp);
    return 8'(((int'(m) * 2) - 3) * amp);
  endfunction

endpackage

// File: rtl/pam4_level_fifo.sv
// rtl/pam4_level_fifo.sv - Power-of-two level buffer with wrapping pointers and an occupancy counter.
module pam4_level_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pam4_level_mapper.sv
// rtl/pam4_level_mapper.sv - Gray PAM4 symbol to signed level mapper with output buffer and drop accounting.
// Optional 1+D precoder enabled by macro PAM4_PRECODE_EN.
module pam4_level_mapper
  import pam4_pkg::*;
#(
  parameter int LEVEL_AMP  = PAM4_LEVEL_AMP_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        symbol_in,
  input  logic              symbol_in_valid,
  output logic signed [7:0] level_out,
  output logic              level_out_valid,
  input  logic              level_out_ready,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [7:0]                    fifo_head;
  logic                          pop;
  logic                          accept;
  logic                          drop;
  pam4_sym_t                     m;

  assign pop    = level_out_valid && level_out_ready;
  assign accept = symbol_in_valid && (!fifo_full || pop);
  assign drop   = symbol_in_valid && fifo_full && !pop;

`ifdef PAM4_PRECODE_EN
  pam4_sym_t prev_m;

  // 2-bit subtraction gives the mod-4 wrap for free.
  assign m = pam4_sym_t'(symbol_in - prev_m);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       prev_m <= '0;
    else if (accept) prev_m <= m;
  end
`else
  assign m = symbol_in;
`endif

  pam4_level_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (accept),
    .push_data (pam4_level(m, LEVEL_AMP)),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign level_out_valid = (fifo_count != '0);
  // Gate the head so stale memory contents never reach the output.
  assign level_out       = fifo_empty ? 8'sd0 : $signed(fifo_head);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pam4_level_mapper.sv
// tb/tb_pam4_level_mapper.sv - Randomized and directed checks of pam4_level_mapper against a queue model.
module tb_pam4_level_mapper;

  localparam int AMP   = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [1:0]        symbol_in = 2'd0;
  logic              symbol_in_valid = 1'b0;
  logic              level_out_ready = 1'b0;
  logic signed [7:0] level_out;
  logic              level_out_valid;
  logic              overflow;
  logic [15:0]       drop_count;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int m_drops = 0;
  bit m_ovf = 1'b0;
  int m_prev = 0;

`ifdef PAM4_PRECODE_EN
  int t1_sym[4]    = '{1, 1, 2, 3};
  int t1_lvl[4]    = '{-32, -96, 32, -32};
  int drain_exp[5] = '{-96, -32, -32, 32, -32};
`else
  int t1_sym[4]    = '{0, 1, 2, 3};
  int t1_lvl[4]    = '{-96, -32, 32, 96};
  int drain_exp[5] = '{-96, -32, 32, 96, 96};
`endif
  int bp_sym[6] = '{0, 1, 2, 3, 0, 1};

  pam4_level_mapper #(
    .LEVEL_AMP  (AMP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .symbol_in       (symbol_in),
    .symbol_in_valid (symbol_in_valid),
    .level_out       (level_out),
    .level_out_valid (level_out_valid),
    .level_out_ready (level_out_ready),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: a bounded queue of levels, computed from the symbol rules directly.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
      m_prev  = 0;
    end else begin
      if (mq.size() > 0 && level_out_ready) void'(mq.pop_front());
      if (symbol_in_valid) begin
        if (mq.size() < DEPTH) begin
          int m;
`ifdef PAM4_PRECODE_EN
          m = (((int'(symbol_in) - m_prev) % 4) + 4) % 4;
`else
          m = int'(symbol_in);
`endif
          mq.push_back((2 * m - 3) * AMP);
          m_prev = m;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", int'(level_out_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk("level", int'(level_out), mq[0]);
    else if (!rstn) chk("rst_level", int'(level_out), 0);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("drop_count", int'(drop_count), m_drops);
  end

  task automatic drive(input bit v, input int s, input bit r);
    symbol_in_valid = v;
    symbol_in       = 2'(s);
    level_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    symbol_in_valid = 1'b0;
    level_out_ready = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_valid", int'(level_out_valid), 0);
    chk("rst_level_imm", int'(level_out), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drops", int'(drop_count), 0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t1_sym[i], 1'b1);
      chk("map_valid", int'(level_out_valid), 1);
      chk("map_level", int'(level_out), t1_lvl[i]);
    end
    drive(1'b0, 0, 1'b1);
    chk("map_drained", int'(level_out_valid), 0);

    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, bp_sym[i], 1'b0);
    chk("bp_overflow", int'(overflow), 1);
    chk("bp_drops", int'(drop_count), 2);
    chk("bp_head", int'(level_out), drain_exp[0]);
    drive(1'b1, 3, 1'b1);
    chk("fullpop_drops", int'(drop_count), 2);
    chk("fullpop_head", int'(level_out), drain_exp[1]);
    for (int i = 2; i < 5; i++) begin
      drive(1'b0, 0, 1'b1);
      chk("drain_level", int'(level_out), drain_exp[i]);
    end
    drive(1'b0, 0, 1'b1);
    chk("drain_empty", int'(level_out_valid), 0);

    for (int i = 0; i < 4; i++) drive(1'b1, i, 1'b0);
    drive(1'b1, 0, 1'b0);
    drive(1'b0, 0, 1'b1);
    chk("pre_rst_overflow", int'(overflow), 1);
    do_reset();
    chk("post_rst_valid", int'(level_out_valid), 0);
    chk("post_rst_overflow", int'(overflow), 0);
    chk("post_rst_drops", int'(drop_count), 0);
    drive(1'b1, 2, 1'b1);
    chk("post_rst_level", int'(level_out), 32);
    drive(1'b0, 0, 1'b1);

    for (int phase = 0; phase < 3; phase++) begin
      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 3) < 3 - phase);
      end
    end

    do_reset();
    symbol_in_valid = 1'b1;
    level_out_ready = 1'b0;
    repeat (DEPTH + 65540) begin
      symbol_in = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    chk("sat_drops", int'(drop_count), 65535);
    chk("sat_overflow", int'(overflow), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", int'(drop_count), 65535);

    symbol_in_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pam4_level_mapper.md
PAM4_LEVEL_MAPPER -- requirements
Module: pam4_level_mapper

Interface
REQ-001 SHALL have parameter LEVEL_AMP, default 32, unit amplitude A; output levels are -3A, -A, +A, +3A.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in entries; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port symbol_in, input, 2 bits: Gray-coded PAM4 symbol from the upstream encoder.
REQ-006 SHALL have port symbol_in_valid, input, 1 bit: symbol_in is valid this cycle; there is no backpressure upstream.
REQ-007 SHALL have port level_out, output, 8 bits, signed: the mapped PAM4 level.
REQ-008 SHALL have port level_out_valid, output, 1 bit: level_out holds a valid level.
REQ-009 SHALL have port level_out_ready, input, 1 bit: the downstream channel model accepts level_out.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a symbol is dropped.
REQ-011 SHALL have port drop_count, output, 16 bits: saturating count of dropped symbols.

Function
REQ-012 SHALL map mapped symbol m as 0->-3A, 1->-A, 2->+A, 3->+3A, computed in at least 10-bit signed arithmetic and truncated to 8 bits; LEVEL_AMP*3 SHALL NOT exceed 127.
REQ-013 SHALL push one entry per cycle in which symbol_in_valid=1 and the buffer is not full; the level is computed at push time and stored.
REQ-014 SHALL treat a handshake as level_out_valid=1 and level_out_ready=1 at a rising edge; each handshake pops exactly one entry.
REQ-015 SHALL drive level_out_valid high iff the buffer is non-empty, and SHALL drive level_out from the head entry.
REQ-016 SHALL give a latency of one cycle: a symbol sampled at edge N into an empty buffer appears with level_out_valid=1 after edge N.
REQ-017 SHALL hold level_out stable while level_out_valid=1 and level_out_ready=0.
REQ-018 SHALL accept the push when the buffer is full and a pop occurs in the same cycle; occupancy stays FIFO_DEPTH.
REQ-019 SHALL accept the push when the buffer is empty and a push arrives; no pop occurs that cycle, because valid was low.
REQ-020 SHALL drop a symbol that arrives while the buffer is full and no pop occurs that cycle.
REQ-021 SHALL, on each drop, set overflow and increment drop_count, which saturates at 16'hFFFF without wrapping.
REQ-022 SHALL keep overflow set until reset; there is no software clear.
REQ-023 SHALL wrap the read and write pointers modulo FIFO_DEPTH, with a separate occupancy counter of width log2(FIFO_DEPTH)+1 that distinguishes full from empty.

Reset
REQ-024 SHALL, while rstn=0, hold level_out=0, level_out_valid=0, overflow=0, drop_count=0, pointers and occupancy at 0, and precoder state at 0.
REQ-025 SHALL, when reset is asserted mid-operation, flush all buffered entries immediately; no pre-reset level is ever presented after rstn rises.

Configuration
REQ-026 SHALL, with macro PAM4_PRECODE_EN defined, apply 1+D precoding: m[n]=(symbol_in[n]-m[n-1]) mod 4, where m[-1]=0.
REQ-027 SHALL update the precoder state only on accepted pushes; dropped symbols leave it unchanged.
REQ-028 SHALL, with PAM4_PRECODE_EN undefined, set m=symbol_in and contain no precoder register.

Structure
REQ-029 SHALL place the pam4_sym_t 2-bit symbol typedef, the level-index constants, and the default LEVEL_AMP in package pam4_pkg, shared with the Gray encoder and the receiver slicer.
REQ-030 SHALL implement buffering in one sub-module, pam4_level_fifo (8-bit data, FIFO_DEPTH entries, push/pop, full/empty/count); the mapping, precoder and overflow logic stay in the top level.

Verification
REQ-031 SHALL verify mapping: with ready=1 and no precode, symbols 0,1,2,3 on consecutive cycles -> level_out -96,-32,32,96 on consecutive cycles, each one cycle after input.
REQ-032 SHALL verify backpressure: ready=0 and 6 valid symbols (0,1,2,3,0,1) -> 4 buffered, symbols 5 and 6 dropped, overflow=1, drop_count=2; then ready=1 -> -96,-32,32,96 emitted.
REQ-033 SHALL verify full with simultaneous pop: buffer full, ready=1, and a valid symbol 3 -> push accepted, count stays 4, drop_count unchanged.
REQ-034 SHALL verify precoding with PAM4_PRECODE_EN: inputs 1,1,2,3 -> m=1,0,2,1 -> levels -32,-96,32,-32.
REQ-035 SHALL verify reset: rstn pulsed low with 3 entries buffered and overflow=1 -> after release, level_out_valid=0, overflow=0, drop_count=0, and the next symbol 2 -> +32.
REQ-036 SHALL verify saturation: 65540 forced drops -> drop_count=16'hFFFF.
